// File: rtl/reg_instr_frame_decoder_pkg.sv
// Shared definitions for the SPI instruction-frame path: opcode bytes,
// decoder FSM encoding and the framing-error cause codes.
package reg_instr_frame_decoder_pkg;

    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    // Frame layout: opcode, addr, data_hi, data_lo, checksum
    localparam int FRAME_BYTES = 5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_CHECK   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_ABORT   = 2'd0,
        ERR_OPCODE  = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage

// File: rtl/reg_instr_frame_decoder_frame_timeout_counter.sv
// Inter-byte gap counter. Counts enabled cycles since the last clear and
// flags expiry on the last allowed cycle so the FSM can abort the frame.
module reg_instr_frame_decoder_frame_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic sysClk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [W-1:0] r_count;

    // Clear has priority; the count never runs past the limit because
    // expiry forces the decoder back to IDLE, which clears the counter.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = (r_count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/reg_instr_frame_decoder.sv
// Decodes 5-byte instruction frames (opcode, addr, data_hi, data_lo,
// checksum) from the SPI slave byte stream into register-table requests.
module reg_instr_frame_decoder
    import reg_instr_frame_decoder_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] P_OP_READ      = OP_READ,
    parameter logic [7:0] P_OP_WRITE     = OP_WRITE
) (
    input  logic        sysClk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        frame_abort,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_data,
    output logic        instr_valid_reg_stuff,
    output logic        reg_write_valid,
    output logic        frame_error,
    output logic [1:0]  error_code,
    output logic        busy
);

    state_t      r_state,   w_state_next;
    logic [7:0]  r_opcode,  w_opcode_next;
    logic [7:0]  r_addr_sh, w_addr_sh_next;
    logic [7:0]  r_hi_sh,   w_hi_sh_next;
    logic [7:0]  r_lo_sh,   w_lo_sh_next;
    logic [7:0]  r_csum,    w_csum_next;
    logic [7:0]  r_reg_addr, w_reg_addr_next;
    logic [15:0] r_reg_data, w_reg_data_next;
    logic        r_rd_valid, w_rd_valid_next;
    logic        r_wr_valid, w_wr_valid_next;
    logic        r_ferr,     w_ferr_next;
    err_code_t   r_err_code, w_err_code_next;

    logic w_idle;
    logic w_expired;

    assign w_idle = (r_state == ST_IDLE);

    reg_instr_frame_decoder_frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .sysClk    (sysClk),
        .rst       (rst),
        .i_clear   (byte_valid | frame_abort | w_expired | w_idle),
        .i_enable  (!w_idle),
        .o_expired (w_expired)
    );

    // State and datapath registers; pulses are registered so they line up
    // with the updated reg_addr/reg_data one cycle after the deciding byte.
    always_ff @(posedge sysClk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_opcode   <= '0;
            r_addr_sh  <= '0;
            r_hi_sh    <= '0;
            r_lo_sh    <= '0;
            r_csum     <= '0;
            r_reg_addr <= '0;
            r_reg_data <= '0;
            r_rd_valid <= 1'b0;
            r_wr_valid <= 1'b0;
            r_ferr     <= 1'b0;
            r_err_code <= ERR_ABORT;
        end else begin
            r_state    <= w_state_next;
            r_opcode   <= w_opcode_next;
            r_addr_sh  <= w_addr_sh_next;
            r_hi_sh    <= w_hi_sh_next;
            r_lo_sh    <= w_lo_sh_next;
            r_csum     <= w_csum_next;
            r_reg_addr <= w_reg_addr_next;
            r_reg_data <= w_reg_data_next;
            r_rd_valid <= w_rd_valid_next;
            r_wr_valid <= w_wr_valid_next;
            r_ferr     <= w_ferr_next;
            r_err_code <= w_err_code_next;
        end
    end

    // Next-state logic: abort beats a byte, a byte beats timeout expiry.
    always_comb begin
        w_state_next    = r_state;
        w_opcode_next   = r_opcode;
        w_addr_sh_next  = r_addr_sh;
        w_hi_sh_next    = r_hi_sh;
        w_lo_sh_next    = r_lo_sh;
        w_csum_next     = r_csum;
        w_reg_addr_next = r_reg_addr;
        w_reg_data_next = r_reg_data;
        w_rd_valid_next = 1'b0;
        w_wr_valid_next = 1'b0;
        w_ferr_next     = 1'b0;
        w_err_code_next = r_err_code;

        if (w_idle) begin
            // Abort in IDLE is harmless; a byte arriving with it is dropped.
            if (byte_valid && !frame_abort) begin
                if (byte_in == P_OP_READ || byte_in == P_OP_WRITE) begin
                    w_opcode_next = byte_in;
                    w_csum_next   = byte_in;
                    w_state_next  = ST_ADDR;
                end else begin
                    w_ferr_next     = 1'b1;
                    w_err_code_next = ERR_OPCODE;
                end
            end
        end else if (frame_abort) begin
            w_ferr_next     = 1'b1;
            w_err_code_next = ERR_ABORT;
            w_state_next    = ST_IDLE;
        end else if (byte_valid) begin
            case (r_state)
                ST_ADDR: begin
                    w_addr_sh_next = byte_in;
                    w_csum_next    = r_csum ^ byte_in;
                    w_state_next   = ST_DATA_HI;
                end
                ST_DATA_HI: begin
                    w_hi_sh_next = byte_in;
                    w_csum_next  = r_csum ^ byte_in;
                    w_state_next = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    w_lo_sh_next = byte_in;
                    w_csum_next  = r_csum ^ byte_in;
                    w_state_next = ST_CHECK;
                end
                ST_CHECK: begin
                    if (byte_in == r_csum) begin
                        w_reg_addr_next = r_addr_sh;
                        w_reg_data_next = {r_hi_sh, r_lo_sh};
                        w_rd_valid_next = (r_opcode == P_OP_READ);
                        w_wr_valid_next = (r_opcode != P_OP_READ);
                    end else begin
                        w_ferr_next     = 1'b1;
                        w_err_code_next = ERR_CSUM;
                    end
                    w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_expired) begin
            w_ferr_next     = 1'b1;
            w_err_code_next = ERR_TIMEOUT;
            w_state_next    = ST_IDLE;
        end

        // Accumulator is only meaningful inside a frame
        if (w_state_next == ST_IDLE) begin
            w_csum_next = '0;
        end
    end

    assign reg_addr              = r_reg_addr;
    assign reg_data              = r_reg_data;
    assign instr_valid_reg_stuff = r_rd_valid;
    assign reg_write_valid       = r_wr_valid;
    assign frame_error           = r_ferr;
    assign error_code            = r_err_code;
    assign busy                  = !w_idle;

endmodule

// File: tb/tb_reg_instr_frame_decoder.sv
// Self-checking bench: directed frames followed by random frame traffic,
// compared every cycle against a byte-queue reference model.
module tb_reg_instr_frame_decoder;

    localparam int T = 32;

    logic        sysClk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        frame_abort = 1'b0;
    logic [7:0]  reg_addr;
    logic [15:0] reg_data;
    logic        instr_valid_reg_stuff;
    logic        reg_write_valid;
    logic        frame_error;
    logic [1:0]  error_code;
    logic        busy;

    reg_instr_frame_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .sysClk                (sysClk),
        .rst                   (rst),
        .byte_in               (byte_in),
        .byte_valid            (byte_valid),
        .frame_abort           (frame_abort),
        .reg_addr              (reg_addr),
        .reg_data              (reg_data),
        .instr_valid_reg_stuff (instr_valid_reg_stuff),
        .reg_write_valid       (reg_write_valid),
        .frame_error           (frame_error),
        .error_code            (error_code),
        .busy                  (busy)
    );

    always #5 sysClk = ~sysClk;

    int errors = 0;
    int checks = 0;

    // Reference model: bytes of the frame in progress, idle cycles since the
    // last accepted byte, and the externally visible results.
    logic [7:0]  m_frame[$];
    int          m_idle = 0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;
    logic [1:0]  m_code = 2'd0;
    logic        e_rd = 1'b0;
    logic        e_wr = 1'b0;
    logic        e_fe = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] csum(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] h, input logic [7:0] l);
        return op ^ a ^ h ^ l;
    endfunction

    task automatic model_reset();
        m_frame.delete();
        m_idle = 0;
        m_addr = 8'h00;
        m_data = 16'h0000;
        m_code = 2'd0;
        e_rd = 1'b0;
        e_wr = 1'b0;
        e_fe = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] b, input bit v, input bit ab);
        logic [7:0] x;
        e_rd = 1'b0;
        e_wr = 1'b0;
        e_fe = 1'b0;
        if (m_frame.size() != 0) begin
            if (ab) begin
                e_fe = 1'b1; m_code = 2'd0; m_frame.delete();
            end else if (v) begin
                m_frame.push_back(b);
                m_idle = 0;
                if (m_frame.size() == 5) begin
                    x = m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3];
                    if (b == x) begin
                        m_addr = m_frame[1];
                        m_data = {m_frame[2], m_frame[3]};
                        if (m_frame[0] == 8'h52) e_rd = 1'b1;
                        else e_wr = 1'b1;
                    end else begin
                        e_fe = 1'b1; m_code = 2'd2;
                    end
                    m_frame.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == T) begin
                    e_fe = 1'b1; m_code = 2'd3; m_frame.delete();
                end
            end
        end else if (v && !ab) begin
            if (b == 8'h52 || b == 8'h57) begin
                m_frame.push_back(b);
                m_idle = 0;
            end else begin
                e_fe = 1'b1; m_code = 2'd1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"}, 32'(reg_addr), 32'(m_addr));
        chk({tag, ".data"}, 32'(reg_data), 32'(m_data));
        chk({tag, ".rd"},   32'(instr_valid_reg_stuff), 32'(e_rd));
        chk({tag, ".wr"},   32'(reg_write_valid), 32'(e_wr));
        chk({tag, ".ferr"}, 32'(frame_error), 32'(e_fe));
        chk({tag, ".code"}, 32'(error_code), 32'(m_code));
        chk({tag, ".busy"}, 32'(busy), 32'(m_frame.size() != 0));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".addr"}, 32'(reg_addr), 32'h0);
        chk({tag, ".data"}, 32'(reg_data), 32'h0);
        chk({tag, ".rd"},   32'(instr_valid_reg_stuff), 32'h0);
        chk({tag, ".wr"},   32'(reg_write_valid), 32'h0);
        chk({tag, ".ferr"}, 32'(frame_error), 32'h0);
        chk({tag, ".code"}, 32'(error_code), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising.
    task automatic cyc(input string tag, input logic [7:0] b, input bit v, input bit ab);
        @(negedge sysClk);
        byte_in = b;
        byte_valid = v;
        frame_abort = ab;
        model_step(b, v, ab);
        @(posedge sysClk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic frame(input string tag, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] h, input logic [7:0] l, input logic [7:0] cs);
        cyc(tag, op, 1'b1, 1'b0);
        cyc(tag, a,  1'b1, 1'b0);
        cyc(tag, h,  1'b1, 1'b0);
        cyc(tag, l,  1'b1, 1'b0);
        cyc(tag, cs, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] fb [5];
        int g;

        // Reset state while held and after release
        #23;
        check_reset_values("rst_hold");
        @(negedge sysClk);
        rst = 1'b0;
        model_reset();
        idle("rst_idle", 2);

        // 1: READ frame, pulse one cycle after the checksum byte
        frame("t1_read", 8'h52, 8'h04, 8'h00, 8'h00, 8'h56);
        chk("t1_rd_pulse", 32'(instr_valid_reg_stuff), 32'h1);
        chk("t1_addr", 32'(reg_addr), 32'h04);
        chk("t1_data", 32'(reg_data), 32'h0000);
        idle("t1_after", 1);
        chk("t1_pulse_single", 32'(instr_valid_reg_stuff), 32'h0);

        // 2: WRITE frame then back-to-back READ with no gap
        frame("t2_write", 8'h57, 8'h10, 8'hAB, 8'hCD, csum(8'h57, 8'h10, 8'hAB, 8'hCD));
        chk("t2_wr_pulse", 32'(reg_write_valid), 32'h1);
        chk("t2_addr", 32'(reg_addr), 32'h10);
        chk("t2_data", 32'(reg_data), 32'hABCD);
        frame("t2_b2b", 8'h52, 8'h00, 8'h00, 8'h00, 8'h52);
        chk("t2_b2b_pulse", 32'(instr_valid_reg_stuff), 32'h1);
        chk("t2_b2b_addr", 32'(reg_addr), 32'h00);
        idle("t2_after", 1);

        // 3: bad checksum keeps previous register values
        frame("t3_badcs", 8'h57, 8'h10, 8'hAB, 8'hCD, 8'h00);
        chk("t3_ferr", 32'(frame_error), 32'h1);
        chk("t3_code", 32'(error_code), 32'h2);
        chk("t3_addr_kept", 32'(reg_addr), 32'h00);
        chk("t3_data_kept", 32'(reg_data), 32'h0000);
        idle("t3_after", 1);

        // 4: bad opcode in IDLE, then a good READ
        cyc("t4_badop", 8'h33, 1'b1, 1'b0);
        chk("t4_code", 32'(error_code), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        frame("t4_read", 8'h52, 8'h07, 8'h12, 8'h34, csum(8'h52, 8'h07, 8'h12, 8'h34));
        chk("t4_addr", 32'(reg_addr), 32'h07);
        idle("t4_after", 1);

        // 5a: timeout after T idle cycles
        cyc("t5_to", 8'h52, 1'b1, 1'b0);
        cyc("t5_to", 8'h04, 1'b1, 1'b0);
        idle("t5_to_wait", T);
        chk("t5_to_ferr", 32'(frame_error), 32'h1);
        chk("t5_to_code", 32'(error_code), 32'h3);
        chk("t5_to_busy", 32'(busy), 32'h0);
        // 5b: byte on the expiry cycle wins
        cyc("t5_edge", 8'h57, 1'b1, 1'b0);
        idle("t5_edge_wait", T - 1);
        cyc("t5_edge", 8'h20, 1'b1, 1'b0);
        chk("t5_edge_busy", 32'(busy), 32'h1);
        cyc("t5_edge", 8'h11, 1'b1, 1'b0);
        cyc("t5_edge", 8'h22, 1'b1, 1'b0);
        cyc("t5_edge", csum(8'h57, 8'h20, 8'h11, 8'h22), 1'b1, 1'b0);
        chk("t5_edge_data", 32'(reg_data), 32'h1122);
        // 5c: abort with the 3rd byte
        cyc("t5_ab", 8'h57, 1'b1, 1'b0);
        cyc("t5_ab", 8'h01, 1'b1, 1'b0);
        cyc("t5_ab", 8'h02, 1'b1, 1'b1);
        chk("t5_ab_code", 32'(error_code), 32'h0);
        chk("t5_ab_busy", 32'(busy), 32'h0);
        // 5d: abort in IDLE is ignored
        cyc("t5_ab_idle", 8'h00, 1'b0, 1'b1);
        idle("t5_after", 1);

        // 6: asynchronous reset mid-frame
        cyc("t6", 8'h57, 1'b1, 1'b0);
        cyc("t6", 8'h33, 1'b1, 1'b0);
        cyc("t6", 8'h44, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        byte_valid = 1'b0;
        frame_abort = 1'b0;
        #1;
        check_reset_values("t6_async_rst");
        model_reset();
        @(negedge sysClk);
        rst = 1'b0;
        idle("t6_post", 1);
        frame("t6_read", 8'h52, 8'h3C, 8'h5A, 8'hA5, csum(8'h52, 8'h3C, 8'h5A, 8'hA5));
        chk("t6_addr", 32'(reg_addr), 32'h3C);
        chk("t6_data", 32'(reg_data), 32'h5AA5);

        // Random frame traffic with gaps, aborts, bad opcodes and checksums
        for (int f = 0; f < 150; f++) begin
            g = int'($urandom_range(0, 99));
            fb[0] = (g < 45) ? 8'h52 : (g < 90) ? 8'h57 : 8'($urandom);
            fb[1] = 8'($urandom);
            fb[2] = 8'($urandom);
            fb[3] = 8'($urandom);
            fb[4] = csum(fb[0], fb[1], fb[2], fb[3]);
            if ($urandom_range(0, 9) == 0) fb[4] = fb[4] ^ (8'h01 << $urandom_range(0, 7));
            for (int i = 0; i < 5; i++) begin
                cyc("rnd_byte", fb[i], 1'b1, ($urandom_range(0, 49) == 0));
                g = ($urandom_range(0, 19) == 0) ? int'($urandom_range(T - 2, T + 1))
                                                 : int'($urandom_range(0, 1));
                for (int k = 0; k < g; k++) begin
                    cyc("rnd_gap", 8'($urandom), 1'b0, ($urandom_range(0, 49) == 0));
                end
            end
        end
        idle("end", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
